// File: rtl/pipe_hazard_int_ctrl.sv
// Pipeline sequencing controller for the 5-stage interrupt-capable MIPS core.
// Decides PC / IF/ID advance, ID/EX bubble and IF flush every cycle, and runs
// the interrupt accept -> drain -> vector sequence plus ERET return.
// It owns the EPC and EXL state.
// Optional feature macro: PIPE_CTRL_INT_EN (interrupt FSM, epc capture, exl set).
module pipe_hazard_int_ctrl #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 3  // legal 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_branch_taken,
  input  logic        id_eret,
  input  logic [31:0] id_npc,
  input  logic        int_req,
  input  logic        sr_ie,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_flush,
  output logic [1:0]  pc_sel,
  output logic [31:0] epc_o,
  output logic        exl_o,
  output logic        int_ack,
  output logic [1:0]  state_o
);

`ifdef PIPE_CTRL_INT_EN
  localparam bit IntEn = 1'b1;
`else
  // Acceptance can never fire, so the FSM stays in RUN and exl is never set.
  localparam bit IntEn = 1'b0;
`endif

  localparam logic [1:0] SelNormal = 2'b00;
  localparam logic [1:0] SelVector = 2'b01;
  localparam logic [1:0] SelEpc    = 2'b10;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StVector = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic        exl_q, exl_d;
  logic        hazard;
  logic        int_accept;

  // Load-use hazard: EX load writes a register the ID instruction reads.
  assign hazard = ex_memread && (ex_rt != 5'd0) &&
                  ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));

  assign int_accept = IntEn && int_req && sr_ie && !exl_q;

  // Next-state and combinational control outputs; reset forces a safe control word.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    epc_d        = epc_q;
    exl_d        = exl_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    if_flush     = 1'b0;
    pc_sel       = SelNormal;
    int_ack      = 1'b0;

    unique case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          if_flush     = 1'b1;
          id_ex_bubble = 1'b1;
          pc_write     = 1'b1;
        end else if (id_eret) begin
          pc_sel   = SelEpc;
          pc_write = 1'b1;
          if_flush = 1'b1;
          exl_d    = 1'b0;
        end else if (hazard) begin
          id_ex_bubble = 1'b1;
        end else if (int_accept) begin
          // The ID instruction is squashed and re-executed after ERET.
          epc_d        = id_npc - 32'd4;
          id_ex_bubble = 1'b1;
          cnt_d        = 3'(DRAIN_CYCLES - 1);
          state_d      = (DRAIN_CYCLES == 1) ? StVector : StDrain;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      StDrain: begin
        id_ex_bubble = 1'b1;
        cnt_d        = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = StVector;
      end
      StVector: begin
        pc_sel       = SelVector;
        pc_write     = 1'b1;
        if_flush     = 1'b1;
        id_ex_bubble = 1'b1;
        int_ack      = 1'b1;
        exl_d        = 1'b1;
        state_d      = StRun;
      end
      default: state_d = StRun;
    endcase

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_flush     = 1'b1;
      pc_sel       = SelNormal;
      int_ack      = 1'b0;
    end
  end

  // State, drain counter, EPC and EXL registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
      epc_q   <= 32'd0;
      exl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      exl_q   <= exl_d;
    end
  end

  assign epc_o   = epc_q;
  assign exl_o   = exl_q;
  assign state_o = state_q;

  // VECTOR_ADDR is consumed by the PC mux outside this block (pc_sel == 01).
  logic [31:0] unused_vector_addr;
  assign unused_vector_addr = VECTOR_ADDR;

endmodule

// File: tb/tb_pipe_hazard_int_ctrl.sv
// Self-checking bench for pipe_hazard_int_ctrl: directed literal checks plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_pipe_hazard_int_ctrl;
  localparam int Drain = 3;
`ifdef PIPE_CTRL_INT_EN
  localparam bit IntEn = 1'b1;
`else
  localparam bit IntEn = 1'b0;
`endif

  logic        clk, rst;
  logic        ex_memread, id_use_rs, id_use_rt, ex_branch_taken, id_eret, int_req, sr_ie;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic [31:0] id_npc;
  logic        pc_write, if_id_write, id_ex_bubble, if_flush, exl_o, int_ack;
  logic [1:0]  pc_sel, state_o;
  logic [31:0] epc_o;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since acceptance (-1 = not in an interrupt sequence).
  int          m_since = -1;
  logic        m_exl   = 1'b0;
  logic [31:0] m_epc   = 32'd0;

  pipe_hazard_int_ctrl #(
    .VECTOR_ADDR (32'h0000_4180),
    .DRAIN_CYCLES(Drain)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_memread     (ex_memread),
    .ex_rt          (ex_rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .ex_branch_taken(ex_branch_taken),
    .id_eret        (id_eret),
    .id_npc         (id_npc),
    .int_req        (int_req),
    .sr_ie          (sr_ie),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_bubble   (id_ex_bubble),
    .if_flush       (if_flush),
    .pc_sel         (pc_sel),
    .epc_o          (epc_o),
    .exl_o          (exl_o),
    .int_ack        (int_ack),
    .state_o        (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_branch_taken = 0; id_eret = 0; int_req = 0; sr_ie = 0; id_npc = 32'h0000_1000;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  // Behavioural model and per-cycle comparison, evaluated mid-cycle.
  always @(negedge clk) begin : cmp
    logic        hz, acc;
    logic        e_pcw, e_ifw, e_bub, e_fl, e_ack;
    logic [1:0]  e_sel, e_st;
    int          n_since;
    logic        n_exl;
    logic [31:0] n_epc;

    if (rst) begin
      m_since = -1; m_exl = 1'b0; m_epc = 32'd0;
    end
    e_pcw = 0; e_ifw = 0; e_bub = 0; e_fl = 0; e_ack = 0; e_sel = 2'b00;
    n_since = m_since; n_exl = m_exl; n_epc = m_epc;
    e_st = (m_since < 0) ? 2'd0 : (m_since == Drain) ? 2'd2 : 2'd1;
    hz  = ex_memread && (ex_rt != 0) &&
          ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
    acc = IntEn && int_req && sr_ie && !m_exl;

    if (rst) begin
      e_bub = 1; e_fl = 1;
    end else if (m_since < 0) begin
      if (ex_branch_taken) begin
        e_fl = 1; e_bub = 1; e_pcw = 1;
      end else if (id_eret) begin
        e_sel = 2'b10; e_pcw = 1; e_fl = 1; n_exl = 0;
      end else if (hz) begin
        e_bub = 1;
      end else if (acc) begin
        e_bub = 1; n_epc = id_npc - 32'd4; n_since = 1;
      end else begin
        e_pcw = 1; e_ifw = 1;
      end
    end else if (m_since == Drain) begin
      e_sel = 2'b01; e_pcw = 1; e_fl = 1; e_bub = 1; e_ack = 1;
      n_exl = 1; n_since = -1;
    end else begin
      e_bub = 1; n_since = m_since + 1;
    end

    chk("pc_write", pc_write, e_pcw);
    chk("if_id_write", if_id_write, e_ifw);
    chk("id_ex_bubble", id_ex_bubble, e_bub);
    chk("if_flush", if_flush, e_fl);
    chk("pc_sel", pc_sel, e_sel);
    chk("int_ack", int_ack, e_ack);
    chk("state_o", state_o, e_st);
    chk("epc_o", epc_o, m_epc);
    chk("exl_o", exl_o, m_exl);

    m_since = n_since; m_exl = n_exl; m_epc = n_epc;
  end

  initial begin
    idle();
    rst = 1'b1;
    smp();
    chk("rst_pc_write", pc_write, 0);
    chk("rst_if_flush", if_flush, 1);
    chk("rst_bubble", id_ex_bubble, 1);
    chk("rst_epc", epc_o, 0);

    cyc(); rst = 1'b0; idle(); smp();
    chk("run_pc_write", pc_write, 1);
    chk("run_if_id_write", if_id_write, 1);

    cyc(); idle(); ex_memread = 1; ex_rt = 8; id_rs = 8; id_use_rs = 1; smp();
    chk("lu_pc_write", pc_write, 0);
    chk("lu_if_id_write", if_id_write, 0);
    chk("lu_bubble", id_ex_bubble, 1);

    cyc(); idle(); ex_memread = 1; ex_rt = 0; id_rs = 0; id_use_rs = 1; smp();
    chk("r0_pc_write", pc_write, 1);
    chk("r0_bubble", id_ex_bubble, 0);

    cyc(); idle(); ex_memread = 1; ex_rt = 8; id_rs = 8; id_use_rs = 1; ex_branch_taken = 1;
    smp();
    chk("br_flush", if_flush, 1);
    chk("br_bubble", id_ex_bubble, 1);
    chk("br_pc_write", pc_write, 1);

    if (IntEn) begin
      cyc(); idle(); sr_ie = 1; int_req = 1; id_npc = 32'h0000_3008; smp();
      chk("acc_state", state_o, 0);
      chk("acc_bubble", id_ex_bubble, 1);
      chk("acc_pc_write", pc_write, 0);
      cyc(); int_req = 0; smp();
      chk("drain1_state", state_o, 1);
      chk("acc_epc", epc_o, 32'h0000_3004);
      cyc(); smp();
      chk("drain2_state", state_o, 1);
      cyc(); smp();
      chk("vec_state", state_o, 2);
      chk("vec_pc_sel", pc_sel, 2'b01);
      chk("vec_ack", int_ack, 1);
      cyc(); int_req = 1; smp();
      chk("post_state", state_o, 0);
      chk("post_exl", exl_o, 1);
      chk("masked_pc_write", pc_write, 1);
      cyc(); id_eret = 1; smp();
      chk("eret_pc_sel", pc_sel, 2'b10);
      chk("eret_flush", if_flush, 1);
      cyc(); id_eret = 0; smp();
      chk("eret_exl", exl_o, 0);
      chk("reacc_bubble", id_ex_bubble, 1);
      chk("reacc_pc_write", pc_write, 0);
      cyc(); int_req = 0; smp();
      chk("reacc_state", state_o, 1);
      cyc(); rst = 1; smp();
      chk("rstd_state", state_o, 0);
      chk("rstd_epc", epc_o, 0);
      chk("rstd_exl", exl_o, 0);
      cyc(); rst = 0; idle(); smp();
      chk("rstd_resume", pc_write, 1);
      cyc(); idle(); sr_ie = 1; int_req = 1; ex_branch_taken = 1; id_npc = 32'h0000_1234; smp();
      chk("brint_state", state_o, 0);
      chk("brint_flush", if_flush, 1);
      chk("brint_pc_write", pc_write, 1);
      cyc(); ex_branch_taken = 0; id_npc = 32'h0000_5004; smp();
      chk("brint_acc", pc_write, 0);
      cyc(); int_req = 0; smp();
      chk("brint_epc", epc_o, 32'h0000_5000);
      chk("brint_drain", state_o, 1);
      for (int i = 0; i < Drain + 1; i++) begin
        cyc(); smp();
      end
      cyc(); id_eret = 1; smp();
      chk("exit_pc_sel", pc_sel, 2'b10);
    end else begin
      cyc(); idle(); sr_ie = 1; int_req = 1; id_npc = 32'h0000_3008; smp();
      chk("noint_pc_write", pc_write, 1);
      chk("noint_ack", int_ack, 0);
      chk("noint_state", state_o, 0);
      cyc(); id_eret = 1; smp();
      chk("noint_eret_sel", pc_sel, 2'b10);
      chk("noint_epc", epc_o, 0);
    end

    // Randomized phase: small register set makes hazards frequent.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst             = ($urandom_range(0, 149) == 0);
      ex_memread      = ($urandom_range(0, 2) == 0);
      ex_rt           = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(8, 10));
      id_rs           = 5'($urandom_range(8, 10));
      id_rt           = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(8, 10));
      id_use_rs       = $urandom_range(0, 1) == 1;
      id_use_rt       = $urandom_range(0, 1) == 1;
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      id_eret         = ($urandom_range(0, 11) == 0);
      int_req         = ($urandom_range(0, 2) != 0);
      sr_ie           = ($urandom_range(0, 4) != 0);
      id_npc          = ($urandom_range(0, 15) == 0) ? 32'd0 : {$urandom} & 32'hFFFF_FFFC;
    end
    cyc(); idle(); rst = 0;
    smp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_int_ctrl.md
# pipe_hazard_int_ctrl

Pipeline sequencing controller for the 5-stage interrupt-capable MIPS core. Each cycle it decides whether the PC and IF/ID registers advance, whether the ID/EX control word is replaced by a bubble, and whether fetched instructions are flushed. It also runs the interrupt entry/exit sequence: accept, drain, vector, and ERET return. It owns the EPC and EXL state.

## Interface
- VECTOR_ADDR, 32'h0000_4180, interrupt handler entry PC
- DRAIN_CYCLES, 3, bubble cycles after acceptance (EX, MEM, WB retire); legal 1..7
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_memread  in  1  EX-stage instruction is a load
- ex_rt  in  5  EX-stage load destination register
- id_rs, id_rt  in  5 each  ID-stage source register numbers
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- id_eret  in  1  ID instruction is ERET
- id_npc  in  32  PC+4 of the ID instruction
- int_req  in  1  level interrupt request
- sr_ie  in  1  status-register interrupt enable
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may update
- id_ex_bubble  out  1  ID/EX control word cleared (drives ID/EX stall)
- if_flush  out  1  squash IF/ID contents
- pc_sel  out  2  00 normal/branch, 01 VECTOR_ADDR, 10 EPC
- epc_o  out  32  saved exception PC
- exl_o  out  1  exception level (handler active)
- int_ack  out  1  one-cycle pulse on vector cycle
- state_o  out  2  FSM state: 0 RUN, 1 DRAIN, 2 VECTOR

## Operation
- Registered state: FSM state, drain counter (3 bits), epc (32), exl (1); all other outputs combinational from state and inputs.
- hazard = ex_memread & ex_rt≠0 & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)).
- RUN, priority highest first:
  - ex_branch_taken: if_flush=1, id_ex_bubble=1, pc_write=1, pc_sel=00.
  - id_eret: pc_sel=10, pc_write=1, if_flush=1, exl cleared next edge.
  - hazard: pc_write=0, if_id_write=0, id_ex_bubble=1 (one-cycle load-use stall).
  - int_req & sr_ie & ~exl: accept. epc ← id_npc−4; the ID instruction is squashed and re-executes after ERET. id_ex_bubble=1, pc_write=0, if_id_write=0, counter ← DRAIN_CYCLES−1, go to DRAIN.
  - else: pc_write=1, if_id_write=1, other controls 0.
- DRAIN: pc_write=0, if_id_write=0, id_ex_bubble=1. Counter decrements. At 0, go to VECTOR. All inputs are ignored.
- VECTOR (one cycle): pc_sel=01, pc_write=1, if_flush=1, id_ex_bubble=1, int_ack=1. exl ← 1. Go to RUN.
- Arithmetic: id_npc−4 is computed modulo 2^32 (id_npc=0 gives FFFF_FFFC).
- Interrupts are masked while exl=1. An ERET clears exl, and the earliest acceptance is the cycle after the ERET.

## Timing
- Stall, flush and bubble decisions take effect in the same cycle as the inputs; the registers they gate update on the next edge.
- Interrupt latency: request seen in RUN at cycle N. DRAIN occupies N+1..N+DRAIN_CYCLES−1, VECTOR is cycle N+DRAIN_CYCLES, and the handler fetch is at N+DRAIN_CYCLES+1. The acceptance cycle counts as the first bubble.
- Reset (anytime, including mid-DRAIN): state=RUN, counter=0, epc_o=0, exl_o=0. While rst is high, pc_write=0, if_id_write=0, id_ex_bubble=1, if_flush=1, pc_sel=00, int_ack=0, state_o=0.
- int_req dropping during DRAIN does not abort the sequence.

## Configuration
- PIPE_CTRL_INT_EN defined: the interrupt FSM, epc capture and exl set are compiled in, as described above.
- Not defined:
  - FSM is fixed in RUN; int_req and sr_ie are ignored.
  - int_ack=0, pc_sel never 01, exl_o never set.
  - ERET still redirects to epc_o (0 after reset); hazard and branch logic are unchanged.

## Test plan
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_use_rs=1 → one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1. The same case with ex_rt=0 gives no stall.
- Branch vs hazard: ex_branch_taken=1 with a hazard present → if_flush=1, id_ex_bubble=1, pc_write=1.
- Interrupt entry: sr_ie=1, int_req=1, id_npc=0x0000_3008 → epc_o=0x0000_3004. state_o goes 0→1→1→2→0 with DRAIN_CYCLES=3. VECTOR cycle shows pc_sel=01 and int_ack=1; exl_o=1 afterwards.
- Masking: exl_o=1 and int_req=1 → no acceptance. ERET gives pc_sel=10 and clears exl; the pending interrupt is accepted one cycle later.
- Reset mid-DRAIN: assert rst while state_o=1 → state_o=0, epc_o=0, exl_o=0 immediately. After release, normal fetch resumes with pc_write=1.
- Branch defers interrupt: int_req=1 together with ex_branch_taken=1 → flush only. Acceptance happens the next cycle, with epc = branch target − 4 + 4 (the id_npc−4 of the target instruction).
